// File: rtl/pc_seq.sv
// Multi-cycle PC sequencer: an FSM that steers fetch, branch, jump, return and trap flow.
// It also keeps the registered interrupt-enable bit and the exception cause code.
module pc_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_ready,
  input  logic [2:0] op_kind,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  input  logic       int_req,
  output logic [2:0] PCSrc,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       RegWrite,
  output logic       EPCWrite,
  output logic       CauseWrite,
  output logic [4:0] cause_code,
  output logic       ie,
  output logic [2:0] state
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] BRANCH = 3'd3;
  localparam logic [2:0] JUMP   = 3'd4;
  localparam logic [2:0] JR     = 3'd5;
  localparam logic [2:0] ERET   = 3'd6;
  localparam logic [2:0] TRAP   = 3'd7;

  localparam logic [2:0] SRC_ALU  = 3'd0;
  localparam logic [2:0] SRC_ALUQ = 3'd1;
  localparam logic [2:0] SRC_JMP  = 3'd2;
  localparam logic [2:0] SRC_GPR  = 3'd3;
  localparam logic [2:0] SRC_EPC  = 3'd4;
  localparam logic [2:0] SRC_VEC  = 3'd5;

  localparam logic [4:0] CAUSE_INT = 5'd0;
  localparam logic [4:0] CAUSE_SYS = 5'd8;
  localparam logic [4:0] CAUSE_ILL = 5'd10;
  localparam logic [4:0] CAUSE_OVF = 5'd12;

  logic [2:0] next_state;
  logic [4:0] next_cause;
  logic       branch_taken;

  assign branch_taken = ((op_kind == 3'b001) && alu_zero) ||
                        ((op_kind == 3'b010) && !alu_zero);

  always_comb begin
    next_state = state;
    next_cause = cause_code;
    PCSrc      = SRC_ALU;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    RegWrite   = 1'b0;
    EPCWrite   = 1'b0;
    CauseWrite = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        // A pending enabled interrupt wins over whatever instruction was decoded.
        if (int_req && ie) begin
          next_state = TRAP;
          next_cause = CAUSE_INT;
        end else begin
          case (op_kind)
            3'b000:         next_state = EXEC;
            3'b001, 3'b010: next_state = BRANCH;
            3'b011:         next_state = JUMP;
            3'b100:         next_state = JR;
            3'b101:         next_state = ERET;
            3'b110: begin
              next_state = TRAP;
              next_cause = CAUSE_SYS;
            end
            default: begin
              next_state = TRAP;
              next_cause = CAUSE_ILL;
            end
          endcase
        end
      end
      EXEC: begin
        if (alu_ovf) begin
          next_state = TRAP;
          next_cause = CAUSE_OVF;
        end else begin
          RegWrite   = 1'b1;
          next_state = FETCH;
        end
      end
      BRANCH: begin
        if (branch_taken) begin
          PCWrite = 1'b1;
          PCSrc   = SRC_ALUQ;
        end
        next_state = FETCH;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSrc      = SRC_JMP;
        next_state = FETCH;
      end
      JR: begin
        PCWrite    = 1'b1;
        PCSrc      = SRC_GPR;
        next_state = FETCH;
      end
      ERET: begin
        PCWrite    = 1'b1;
        PCSrc      = SRC_EPC;
        next_state = FETCH;
      end
      default: begin
        EPCWrite   = 1'b1;
        CauseWrite = 1'b1;
        PCWrite    = 1'b1;
        PCSrc      = SRC_VEC;
        next_state = FETCH;
      end
    endcase
    if (rst) begin
      PCSrc      = SRC_ALU;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      RegWrite   = 1'b0;
      EPCWrite   = 1'b0;
      CauseWrite = 1'b0;
    end
  end

  // The cause code is only captured on entry to TRAP, so it stays readable afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      ie         <= 1'b0;
      cause_code <= 5'd0;
    end else begin
      state <= next_state;
      if (next_state == TRAP && state != TRAP)
        cause_code <= next_cause;
      if (state == ERET)
        ie <= 1'b1;
      else if (state == TRAP)
        ie <= 1'b0;
    end
  end

endmodule
